// File: rtl/jtkcpu_busclk.sv
// CPU bus-cycle clock-enable generator: divides cen2 into DIV phases, with wait states and bus grant.
// Optional dtack watchdog enabled by defining JTKCPU_WDOG_EN.
module jtkcpu_busclk #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned WSW      = 3,
  parameter int unsigned WDOG_LMT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen2,
  input  logic                    dtack,
  input  logic                    bus_acc,
  input  logic [WSW-1:0]          ws_cfg,
  input  logic                    bus_req,
  output logic                    bus_gnt,
  output logic                    cen,
  output logic                    cen_x2,
  output logic [$clog2(DIV)-1:0]  phase,
  output logic                    stall,
  output logic                    dtack_to
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("jtkcpu_busclk: DIV must be at least 2");
  end
  if (WDOG_LMT < 1 || WDOG_LMT > 255) begin : g_bad_lmt
    $error("jtkcpu_busclk: WDOG_LMT must be 1..255");
  end

  logic [WSW-1:0] ws_cnt;
  logic           wdog_fire;
  logic           dtack_eff;
  logic           adv;
  logic           last;

`ifdef JTKCPU_WDOG_EN
  logic [7:0] wdog_cnt;

  // Firing on the count that would reach the limit makes this very cen2 the forced-ready one.
  assign wdog_fire = cen2 & ~dtack & ~bus_gnt & (wdog_cnt == 8'(WDOG_LMT - 1));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      dtack_to <= 1'b0;
    end else begin
      dtack_to <= wdog_fire;
      if (cen2) begin
        if (dtack || wdog_fire) wdog_cnt <= '0;
        else if (!bus_gnt)      wdog_cnt <= wdog_cnt + 8'd1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign dtack_to  = 1'b0;
`endif

  assign dtack_eff = dtack | wdog_fire;
  assign adv       = cen2 & dtack_eff & ~stall & ~bus_gnt;
  assign last      = (phase == PH_LAST);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      cen     <= 1'b0;
      cen_x2  <= 1'b0;
      stall   <= 1'b0;
      bus_gnt <= 1'b0;
      ws_cnt  <= '0;
    end else begin
      cen_x2 <= adv;
      cen    <= adv & last;
      if (adv) begin
        phase <= last ? '0 : phase + PW'(1);
        if (last) begin
          // A pending access takes priority; the request is looked at again next boundary.
          if (bus_acc && ws_cfg != '0) begin
            ws_cnt <= ws_cfg;
            stall  <= 1'b1;
          end else if (!bus_acc && bus_req) begin
            bus_gnt <= 1'b1;
          end
        end
      end
      if (stall && cen2 && dtack_eff) begin
        ws_cnt <= ws_cnt - WSW'(1);
        if (ws_cnt == WSW'(1)) stall <= 1'b0;
      end
      if (bus_gnt && cen2 && !bus_req) bus_gnt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtkcpu_busclk.sv
// Scoreboard bench for jtkcpu_busclk: a slot-level reference model predicts each cen2 outcome,
// a monitor compares whenever the DUT registers a cen2 slot.
module tb_jtkcpu_busclk;

  localparam int unsigned DIV      = 4;
  localparam int unsigned WSW      = 3;
  localparam int unsigned WDOG_LMT = 4;

  logic           clk = 1'b1;
  logic           rst_n = 1'b0;
  logic           cen2 = 1'b0;
  logic           dtack = 1'b1;
  logic           bus_acc = 1'b0;
  logic [WSW-1:0] ws_cfg = '0;
  logic           bus_req = 1'b0;
  logic           bus_gnt, cen, cen_x2, stall, dtack_to;
  logic [1:0]     phase;

  jtkcpu_busclk #(.DIV(DIV), .WSW(WSW), .WDOG_LMT(WDOG_LMT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen2     (cen2),
    .dtack    (dtack),
    .bus_acc  (bus_acc),
    .ws_cfg   (ws_cfg),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .cen      (cen),
    .cen_x2   (cen_x2),
    .phase    (phase),
    .stall    (stall),
    .dtack_to (dtack_to)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cx2;
    logic       cen;
    logic [1:0] ph;
    logic       stall;
    logic       gnt;
    logic       dto;
  } exp_t;

  exp_t slot_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state, in CPU-cycle terms
  int m_pos, m_waits, m_wd;
  bit m_gnt;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_waits = 0; m_wd = 0; m_gnt = 0;
  endfunction

  function automatic exp_t model_step(bit d, bit acc, int ws, bit req);
    exp_t e;
    bit   fire = 0;
    bit   ok;
    bit   moved = 0;
    bit   wrapped = 0;
`ifdef JTKCPU_WDOG_EN
    if (d) m_wd = 0;
    else if (!m_gnt) begin
      m_wd++;
      if (m_wd == WDOG_LMT) begin
        fire = 1;
        m_wd = 0;
      end
    end
`endif
    ok = d | fire;
    if (m_gnt) begin
      if (!req) m_gnt = 0;
    end else if (m_waits > 0) begin
      if (ok) m_waits--;
    end else if (ok) begin
      moved   = 1;
      wrapped = (m_pos == DIV - 1);
      m_pos   = (m_pos + 1) % DIV;
      if (wrapped) begin
        if (acc && ws != 0)   m_waits = ws;
        else if (!acc && req) m_gnt = 1;
      end
    end
    e.cx2   = moved;
    e.cen   = moved & wrapped;
    e.ph    = 2'(m_pos);
    e.stall = (m_waits > 0);
    e.gnt   = m_gnt;
    e.dto   = fire;
    return e;
  endfunction

  // Monitor: a cen2 still high at the rising edge means its result is now registered.
  always @(posedge clk) begin
    if (rst_n) begin
      if (cen2) begin
        if (slot_q.size() == 0) begin
          check("slot_queue_underflow", 1, 0);
        end else begin
          exp_t e;
          e = slot_q.pop_front();
          check("cen_x2", int'(cen_x2), int'(e.cx2));
          check("cen", int'(cen), int'(e.cen));
          check("phase", int'(phase), int'(e.ph));
          check("stall", int'(stall), int'(e.stall));
          check("bus_gnt", int'(bus_gnt), int'(e.gnt));
          check("dtack_to", int'(dtack_to), int'(e.dto));
        end
      end else begin
        check("idle_cen_x2", int'(cen_x2), 0);
        check("idle_cen", int'(cen), 0);
        check("idle_dtack_to", int'(dtack_to), 0);
      end
    end
  end

  task automatic slot(bit d, bit acc, int ws, bit req, int gap);
    @(posedge clk);
    #1;
    dtack   = d;
    bus_acc = acc;
    ws_cfg  = WSW'(ws);
    bus_req = req;
    slot_q.push_back(model_step(d, acc, ws, req));
    cen2 = 1'b1;
    @(posedge clk);
    #1;
    cen2 = 1'b0;
    // Inputs outside a cen2 slot must be ignored
    dtack   = 1'($urandom);
    bus_acc = 1'($urandom);
    ws_cfg  = WSW'($urandom);
    bus_req = 1'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_cen"}, int'(cen), 0);
    check({tag, "_cen_x2"}, int'(cen_x2), 0);
    check({tag, "_stall"}, int'(stall), 0);
    check({tag, "_bus_gnt"}, int'(bus_gnt), 0);
    check({tag, "_dtack_to"}, int'(dtack_to), 0);
  endtask

  task automatic pulse_reset(string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain sequencing, cen2 every 4 clk
    for (int i = 0; i < 8; i++) slot(1, 0, 0, 0, 2);

    // Three wait states at a boundary
    for (int i = 0; i < 3; i++) slot(1, 0, 0, 0, 1);
    slot(1, 1, 3, 0, 1);
    for (int i = 0; i < 8; i++) slot(1, 0, 0, 0, 1);

    // Request mid-cycle, then release
    for (int i = 0; i < 7; i++) slot(1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) slot(1, 0, 0, 0, 0);

    // Access and request at the same boundary
    for (int i = 0; i < 4; i++) slot(1, 1, 2, 1, 1);
    for (int i = 0; i < 8; i++) slot(1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) slot(1, 0, 0, 0, 1);

    // dtack low for 5 slots, then a long stretch for the watchdog
    while (m_pos != 1) slot(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) slot(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) slot(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) slot(0, 0, 0, 0, 1);

    // Reset while stalled
    for (int i = 0; i < 20 && m_waits < 2; i++) slot(1, 1, 3, 0, 1);
    check("pre_reset_stall", int'(stall), int'(m_waits > 0));
    pulse_reset("rst_stall");
    for (int i = 0; i < 4; i++) slot(1, 0, 0, 0, 1);

    // Reset while granted
    for (int i = 0; i < 20 && !m_gnt; i++) slot(1, 0, 0, 1, 1);
    check("pre_reset_gnt", int'(bus_gnt), int'(m_gnt));
    pulse_reset("rst_gnt");

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      slot(($urandom_range(0, 9) < 8), 1'($urandom), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clk);
    check("slot_queue_drained", slot_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
